// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared constants for the architectural register file and its
//               read ports: data width and default index/tag widths.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;
    localparam int DATA_WIDTH          = 32;
    localparam int DEF_REG_NUM_WIDTH   = 5;
    localparam int DEF_ROB_SIZE_WIDTH  = 5;
endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_read_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_read_port
// Description : One combinational operand lookup. It takes the stored state of
//               the selected register and applies the same-cycle commit bypass.
// Ports       : rs              - source register index
//               reg_value/busy/dep - stored state of register rs
//               commit_valid    - a commit to a nonzero rd is presented
//               commit_rd/value/rob_id - commit payload
//               value/busy/dep  - resolved operand
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int REG_NUM_WIDTH  = DEF_REG_NUM_WIDTH,
    parameter int ROB_SIZE_WIDTH = DEF_ROB_SIZE_WIDTH
) (
    input  logic [REG_NUM_WIDTH-1:0]  rs,
    input  logic [DATA_WIDTH-1:0]     reg_value,
    input  logic                      reg_busy,
    input  logic [ROB_SIZE_WIDTH-1:0] reg_dep,
    input  logic                      commit_valid,
    input  logic [REG_NUM_WIDTH-1:0]  commit_rd,
    input  logic [DATA_WIDTH-1:0]     commit_value,
    input  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
    output logic [DATA_WIDTH-1:0]     value,
    output logic                      busy,
    output logic [ROB_SIZE_WIDTH-1:0] dep
);

    logic w_bypass;

    // The producer this operand waits on is retiring right now.
    assign w_bypass = commit_valid && (commit_rd == rs) && (reg_dep == commit_rob_id);

    always_comb begin
        value = reg_value;
        busy  = reg_busy;
        dep   = reg_dep;
        if (rs == '0) begin
            value = '0;
            busy  = 1'b0;
            dep   = '0;
        end else if (reg_busy && w_bypass) begin
            value = commit_value;
            busy  = 1'b0;
        end
    end

endmodule : reg_file_read_port
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Architectural register file with rename tags. Each register
//               holds a value, a busy bit and the ROB id of its pending
//               producer. The decoder renames destinations at issue, and the
//               ROB retires values through the commit channel. A flush clears
//               every busy bit.
// Ports       : clk_in, rst_in (sync, active-high), rdy_in (global enable)
//               rob2rf_*        - commit channel from the reorder buffer
//               need_flush_in   - misprediction flush
//               dec_*           - issue rename and source indices
//               rf2dec_*        - combinational operand lookups (2 ports)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_NUM_WIDTH  = DEF_REG_NUM_WIDTH,
    parameter int ROB_SIZE_WIDTH = DEF_ROB_SIZE_WIDTH
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      rob2rf_ready,
    input  logic [REG_NUM_WIDTH-1:0]  rob2rf_rd,
    input  logic [DATA_WIDTH-1:0]     rob2rf_value,
    input  logic [ROB_SIZE_WIDTH-1:0] rob2rf_rob_id,
    input  logic                      need_flush_in,
    input  logic                      dec_valid,
    input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
    input  logic [ROB_SIZE_WIDTH-1:0] dec_rob_id,
    input  logic [REG_NUM_WIDTH-1:0]  dec_rs1,
    input  logic [REG_NUM_WIDTH-1:0]  dec_rs2,
    output logic [DATA_WIDTH-1:0]     rf2dec_value1,
    output logic [DATA_WIDTH-1:0]     rf2dec_value2,
    output logic                      rf2dec_busy1,
    output logic                      rf2dec_busy2,
    output logic [ROB_SIZE_WIDTH-1:0] rf2dec_dep1,
    output logic [ROB_SIZE_WIDTH-1:0] rf2dec_dep2
);

    localparam int REG_NUM = 1 << REG_NUM_WIDTH;

    logic [DATA_WIDTH-1:0]     r_value [REG_NUM];
    logic                      r_busy  [REG_NUM];
    logic [ROB_SIZE_WIDTH-1:0] r_dep   [REG_NUM];

    logic w_commit;
    logic w_issue;

    assign w_commit = rob2rf_ready && (rob2rf_rd != '0);
    // An issue in a flush cycle belongs to the squashed path.
    assign w_issue  = dec_valid && (dec_rd != '0) && !need_flush_in;

    // x0 is never written, so its entries hold their reset value of zero.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_value[i] <= '0;
                r_busy[i]  <= 1'b0;
                r_dep[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (need_flush_in) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    r_busy[i] <= 1'b0;
                end
            end
            if (w_commit) begin
                r_value[rob2rf_rd] <= rob2rf_value;
                // Only the producer the register still waits on clears it;
                // a younger rename keeps it busy.
                if (r_busy[rob2rf_rd] && (r_dep[rob2rf_rd] == rob2rf_rob_id)) begin
                    r_busy[rob2rf_rd] <= 1'b0;
                end
            end
            // Issued last so that it overrides a same-register commit.
            if (w_issue) begin
                r_busy[dec_rd] <= 1'b1;
                r_dep[dec_rd]  <= dec_rob_id;
            end
        end
    end

    reg_file_read_port #(
        .REG_NUM_WIDTH  (REG_NUM_WIDTH),
        .ROB_SIZE_WIDTH (ROB_SIZE_WIDTH)
    ) u_read_port1 (
        .rs            (dec_rs1),
        .reg_value     (r_value[dec_rs1]),
        .reg_busy      (r_busy[dec_rs1]),
        .reg_dep       (r_dep[dec_rs1]),
        .commit_valid  (w_commit),
        .commit_rd     (rob2rf_rd),
        .commit_value  (rob2rf_value),
        .commit_rob_id (rob2rf_rob_id),
        .value         (rf2dec_value1),
        .busy          (rf2dec_busy1),
        .dep           (rf2dec_dep1)
    );

    reg_file_read_port #(
        .REG_NUM_WIDTH  (REG_NUM_WIDTH),
        .ROB_SIZE_WIDTH (ROB_SIZE_WIDTH)
    ) u_read_port2 (
        .rs            (dec_rs2),
        .reg_value     (r_value[dec_rs2]),
        .reg_busy      (r_busy[dec_rs2]),
        .reg_dep       (r_dep[dec_rs2]),
        .commit_valid  (w_commit),
        .commit_rd     (rob2rf_rd),
        .commit_value  (rob2rf_value),
        .commit_rob_id (rob2rf_rob_id),
        .value         (rf2dec_value2),
        .busy          (rf2dec_busy2),
        .dep           (rf2dec_dep2)
    );

endmodule : reg_file
`default_nettype wire
